ram_loader: RTL and testbench
=============================

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter VERIFY, default 1, meaning read-back check of each written byte is enabled when 1 and skipped when 0.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of RAM locations addressable by the 4-bit address.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin a load session; sampled only in IDLE, DONE or ERROR.
REQ-006 len  input  5  number of bytes to load, 0..16; values above DEPTH are treated as DEPTH.
REQ-007 in_data  input  8  program byte offered by the source.
REQ-008 in_valid  input  1  source has a byte on in_data.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 addr  output  4  RAM address driven to the memory.
REQ-011 ram_write  output  1  RAM write strobe; RAM captures bus on the rising edge where this is high.
REQ-012 ram_read  output  1  RAM read enable; RAM drives bus combinationally while high.
REQ-013 bus  inout  8  shared data bus; driven by the loader only during WRITE, else high-Z.
REQ-014 busy  output  1  session in progress; CPU must hold off bus use.
REQ-015 done  output  1  level, session completed without error.
REQ-016 error  output  1  level, read-back mismatch detected.
REQ-017 err_addr  output  4  address of the first mismatching byte.

Function
REQ-018 SHALL implement states IDLE, WAIT_BYTE, WRITE, VERIFY, DONE, ERROR.
REQ-019 IDLE/DONE/ERROR + start=1: if effective len=0 go DONE; otherwise clear addr to 0, load remaining-count from effective len, clear done/error, and go to WAIT_BYTE.
REQ-020 start SHALL be ignored in WAIT_BYTE, WRITE and VERIFY.
REQ-021 in_ready SHALL be 1 only in WAIT_BYTE; a transfer occurs on a rising edge with in_valid=1 and in_ready=1, latching in_data and moving to WRITE.
REQ-022 in_valid without in_ready SHALL have no effect; WAIT_BYTE is held indefinitely until a transfer occurs.
REQ-023 WRITE lasts exactly one cycle: ram_write=1, ram_read=0, bus driven with the latched byte, addr stable.
REQ-024 After WRITE: VERIFY=1 goes to VERIFY; VERIFY=0 performs the advance step (REQ-026).
REQ-025 VERIFY lasts exactly one cycle: ram_read=1, ram_write=0, bus high-Z, same addr; bus is compared to the latched byte at the closing edge; a mismatch sets err_addr=addr and goes to ERROR.
REQ-026 Advance step: decrement the remaining count; if it reaches 0 go to DONE with addr unchanged; otherwise increment addr modulo 16 and go to WAIT_BYTE.
REQ-027 Per-byte throughput SHALL be 3 cycles with VERIFY=1 and 2 cycles with VERIFY=0 when in_valid is held high.
REQ-028 ram_read and ram_write SHALL never be high in the same cycle, and bus SHALL never be driven while ram_read=1.
REQ-029 busy=1 in WAIT_BYTE, WRITE and VERIFY; busy=0 otherwise.
REQ-030 done=1 only in DONE, and error=1 only in ERROR; both hold until the next accepted start or reset.

Reset
REQ-031 reset=1 SHALL immediately, without waiting for a clock edge, force IDLE, addr=0, remaining-count=0, err_addr=0, in_ready=0, ram_write=0, ram_read=0, busy=0, done=0, error=0, and bus high-Z.
REQ-032 Reset during WRITE SHALL drop ram_write before the next edge, so no partial write occurs; the bytes already written remain in RAM.

Verification
REQ-033 Load len=6 with bytes 19,50,1F,30,24,70 and in_valid held high -> RAM[0..5] hold these bytes, done=1 at cycle 18 after start, error=0.
REQ-034 len=0 start -> DONE next cycle; ram_write is never asserted.
REQ-035 len=20 with 16 bytes supplied -> addresses 0..15 are written, addr ends at F, done=1, and no wrap to 0.
REQ-036 in_valid toggled 1-0-0-1 during a len=2 load -> WAIT_BYTE holds, both bytes land at addr 0 and 1, and there is no extra write.
REQ-037 Force the bus to AA during VERIFY at addr 3 -> error=1, err_addr=3, done=0, busy=0.
REQ-038 Assert reset mid-WRITE at addr 2 -> ram_write=0 and bus=Z at once, then state IDLE; a new start reloads from addr 0.

Source files
------------

// File: rtl/ram_loader.sv
// Program loader: takes bytes from a valid/ready source and writes them in
// sequence into a shared-bus RAM. Each byte can optionally be read back and checked.
module ram_loader #(
  parameter bit          VERIFY = 1'b1,
  parameter int unsigned DEPTH  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] len,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] addr,
  output logic       ram_write,
  output logic       ram_read,
  inout  wire  [7:0] bus,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] err_addr
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 5;
  localparam logic [LW-1:0] DEPTH_LEN = LW'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BYTE,
    ST_WRITE,
    ST_VERIFY,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [AW-1:0] addr_d, err_addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [LW-1:0] eff_len;
  logic          advance;

  // Requests longer than the RAM are clamped to its depth
  assign eff_len = (len > DEPTH_LEN) ? DEPTH_LEN : len;

  // The bus is driven only while the write strobe is high
  assign bus = ram_write ? data_q : {DW{1'bz}};

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    addr_d     = addr;
    rem_d      = rem_q;
    data_d     = data_q;
    err_addr_d = err_addr;
    advance    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          if (eff_len == '0) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = '0;
            rem_d   = eff_len;
            state_d = ST_WAIT_BYTE;
          end
        end
      end
      ST_WAIT_BYTE: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (VERIFY) state_d = ST_VERIFY;
        else        advance = 1'b1;
      end
      ST_VERIFY: begin
        if (bus != data_q) begin
          err_addr_d = addr;
          state_d    = ST_ERROR;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The last byte leaves addr on its own location, so there is no wrap after a full load
    if (advance) begin
      rem_d = rem_q - LW'(1);
      if (rem_q == LW'(1)) begin
        state_d = ST_DONE;
      end else begin
        addr_d  = addr + AW'(1);
        state_d = ST_WAIT_BYTE;
      end
    end
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr      <= '0;
      rem_q     <= '0;
      data_q    <= '0;
      err_addr  <= '0;
      in_ready  <= 1'b0;
      ram_write <= 1'b0;
      ram_read  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr      <= addr_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      err_addr  <= err_addr_d;
      in_ready  <= (state_d == ST_WAIT_BYTE);
      ram_write <= (state_d == ST_WRITE);
      ram_read  <= (state_d == ST_VERIFY);
      busy      <= (state_d == ST_WAIT_BYTE) || (state_d == ST_WRITE) || (state_d == ST_VERIFY);
      done      <= (state_d == ST_DONE);
      error     <= (state_d == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: a RAM model on the shared bus, a scoreboard of expected writes,
// and directed load sessions with hand-computed completion cycles.
module tb_ram_loader;

  localparam int BUDGET = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [4:0] len = '0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, ram_write, ram_read, busy, done, error;
  logic [3:0] addr, err_addr;
  wire  [7:0] bus;

  logic [7:0] mem     [16];
  logic [7:0] exp_mem [16];
  logic       corrupt_en = 1'b0;
  logic [3:0] corrupt_addr = '0;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_wq[$];
  logic [7:0] src_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  ram_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .addr     (addr),
    .ram_write(ram_write),
    .ram_read (ram_read),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, write on the rising edge; one location can be corrupted
  assign bus = ram_read ? ((corrupt_en && addr == corrupt_addr) ? 8'hAA : mem[addr]) : 8'hzz;
  always @(posedge clk) if (ram_write) mem[addr] <= bus;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // A write seen in one cycle counts only if no reset arrives before the next negedge
  logic pend_v = 1'b0;
  wr_t  pend;
  wr_t  e;
  always @(negedge clk) begin
    if (reset) begin
      pend_v = 1'b0;
    end else begin
      if (pend_v) begin
        check("write_expected", 32'(exp_wq.size() > 0), 1);
        if (exp_wq.size() > 0) begin
          e = exp_wq.pop_front();
          check("write_addr", 32'(pend.a), 32'(e.a));
          check("write_data", 32'(pend.d), 32'(e.d));
        end
      end
      pend_v = ram_write;
      pend.a = addr;
      pend.d = bus;
      check("rd_wr_exclusive", 32'(ram_read && ram_write), 0);
      check("status_exclusive", 32'($countones({busy, done, error}) > 1), 0);
      check("strobe_needs_busy", 32'((in_ready || ram_write || ram_read) && !busy), 0);
    end
  end

  // Queue source bytes; the first n_wr of them are expected to reach addresses 0..n_wr-1
  task automatic plan(input logic [7:0] b[$], input int n_wr);
    for (int i = 0; i < b.size(); i++) begin
      src_q.push_back(b[i]);
      if (i < n_wr) begin
        exp_wq.push_back('{a: 4'(i % 16), d: b[i]});
        exp_mem[i % 16] = b[i];
      end
    end
  endtask

  // Start a session; k is the edge index after start at which done/error is first seen
  task automatic session(input logic [4:0] l, input logic [63:0] gap, input int abort_k,
                         output int k);
    bit xfer;
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(done || error) && k < BUDGET) begin
      k++;
      in_valid = (src_q.size() > 0) && !((k < 64) && gap[6'(k)]);
      in_data  = in_valid ? src_q[0] : 8'h00;
      xfer     = in_valid && in_ready;
      @(posedge clk);
      if (xfer) void'(src_q.pop_front());
      @(negedge clk);
      if (k == abort_k) break;
    end
    in_valid = 1'b0;
    if (k != abort_k) check("session_completes", 32'(done || error), 1);
  endtask

  initial begin
    logic [7:0] bq[$];
    int k;
    for (int i = 0; i < 16; i++) begin
      mem[i] <= 8'h00;
      exp_mem[i] = 8'h00;
    end

    #2 reset = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_ram_write", 32'(ram_write), 0);
    check("rst_ram_read", 32'(ram_read), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_err_addr", 32'(err_addr), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Offered data in IDLE must be ignored
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("idle_no_ready", 32'(in_ready), 0);

    // Six bytes back to back: 3 cycles per byte
    bq = '{8'h19, 8'h50, 8'h1F, 8'h30, 8'h24, 8'h70};
    plan(bq, 6);
    session(5'd6, 64'h0, -1, k);
    check("len6_cycles", 32'(k), 18);
    check("len6_done", 32'(done), 1);
    check("len6_error", 32'(error), 0);
    check("len6_addr", 32'(addr), 5);
    check("len6_mem0", 32'(mem[0]), 32'h19);
    check("len6_mem5", 32'(mem[5]), 32'h70);

    // Zero length from IDLE: done on the first edge, no write
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    session(5'd0, 64'h0, -1, k);
    check("len0_cycles", 32'(k), 0);
    check("len0_done", 32'(done), 1);
    check("len0_busy", 32'(busy), 0);

    // Oversized length clamps to 16 locations without wrapping
    bq.delete();
    for (int i = 0; i < 16; i++) bq.push_back(8'(8'hA0 + i));
    plan(bq, (20 > 16) ? 16 : 20);
    session(5'd20, 64'h0, -1, k);
    check("len20_cycles", 32'(k), 48);
    check("len20_addr", 32'(addr), 15);
    check("len20_done", 32'(done), 1);
    check("len20_src_used", 32'(src_q.size()), 0);

    // Valid drops for edges 2..5; the last two fall in WAIT_BYTE and stall it
    bq = '{8'h11, 8'h22};
    plan(bq, 2);
    session(5'd2, 64'h3C, -1, k);
    check("stall_cycles", 32'(k), 8);
    check("stall_addr", 32'(addr), 1);
    check("stall_done", 32'(done), 1);

    // Read-back corrupted at address 3
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    plan(bq, 4);
    corrupt_en   = 1'b1;
    corrupt_addr = 4'd3;
    session(5'd6, 64'h0, -1, k);
    corrupt_en = 1'b0;
    src_q.delete();
    check("err_cycles", 32'(k), 12);
    check("err_error", 32'(error), 1);
    check("err_err_addr", 32'(err_addr), 3);
    check("err_done", 32'(done), 0);
    check("err_busy", 32'(busy), 0);

    // Reset while writing address 2: strobe drops at once, earlier bytes stay
    bq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    plan(bq, 2);
    session(5'd4, 64'h0, 7, k);
    check("abort_in_write", 32'(ram_write), 1);
    check("abort_addr_before", 32'(addr), 2);
    reset = 1'b1;
    #1;
    check("abort_ram_write", 32'(ram_write), 0);
    check("abort_ram_read", 32'(ram_read), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_addr", 32'(addr), 0);
    src_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    bq = '{8'hD1, 8'hD2};
    plan(bq, 2);
    session(5'd2, 64'h0, -1, k);
    check("reload_cycles", 32'(k), 6);
    check("reload_addr", 32'(addr), 1);
    check("reload_done", 32'(done), 1);

    repeat (3) @(negedge clk);
    check("writes_all_seen", 32'(exp_wq.size()), 0);
    for (int i = 0; i < 16; i++) check($sformatf("mem_%0d", i), 32'(mem[i]), 32'(exp_mem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
